// File: rtl/vision_pkg.sv
// Shared vision constants: screen region boundaries, region result encoding
// and the region-detect FSM state type.
package vision_pkg;

    localparam int unsigned PIX_W       = 10;
    localparam int unsigned COL_W       = 8;
    localparam int unsigned CNT_W       = 17;
    localparam int unsigned NUM_REGIONS = 4;
    localparam int unsigned REG_W       = 2;
    localparam int unsigned HOLD_W      = 8;

    localparam logic [PIX_W-1:0] X_REG1  = 10'd160;
    localparam logic [PIX_W-1:0] X_REG2  = 10'd320;
    localparam logic [PIX_W-1:0] X_REG3  = 10'd480;
    localparam logic [PIX_W-1:0] X_LIMIT = 10'd640;
    localparam logic [PIX_W-1:0] Y_LIMIT = 10'd480;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [REG_W-1:0] region_idx_t;

    // vld=0 encodes "no region won"
    typedef struct packed {
        logic        vld;
        region_idx_t idx;
    } region_res_t;

    localparam region_res_t REGION_NONE = '{vld: 1'b0, idx: '0};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        CMP,
        UPD
    } det_state_t;

    function automatic logic [NUM_REGIONS-1:0] region_onehot(input region_res_t r);
        return r.vld ? (NUM_REGIONS'(1) << r.idx) : '0;
    endfunction

endpackage

// File: rtl/glove_pixel_classify.sv
// Combinational glove-colour test and screen-region lookup for one pixel.
module glove_pixel_classify
    import vision_pkg::*;
#(
    parameter logic [COL_W-1:0] R_MIN = 8'd150,
    parameter logic [COL_W-1:0] G_MAX = 8'd100,
    parameter logic [COL_W-1:0] B_MAX = 8'd100
) (
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  x_pos,
    input  logic [PIX_W-1:0]  y_pos,
    input  logic [COL_W-1:0]  r,
    input  logic [COL_W-1:0]  g,
    input  logic [COL_W-1:0]  b,
    output logic              hit_c,
    output region_idx_t       region_c
);

    always_comb begin
        hit_c = pix_valid && (x_pos < X_LIMIT) && (y_pos < Y_LIMIT) &&
                (r >= R_MIN) && (g <= G_MAX) && (b <= B_MAX);

        if (x_pos < X_REG1) begin
            region_c = 2'd0;
        end else if (x_pos < X_REG2) begin
            region_c = 2'd1;
        end else if (x_pos < X_REG3) begin
            region_c = 2'd2;
        end else begin
            region_c = 2'd3;
        end
    end

endmodule

// File: rtl/glove_region_detect.sv
// Per-frame glove pixel counting over four vertical screen regions; flags the
// winning region. Optional DEBOUNCE_EN holds flags until a result repeats.
module glove_region_detect
    import vision_pkg::*;
#(
    parameter logic [COL_W-1:0] R_MIN        = 8'd150,
    parameter logic [COL_W-1:0] G_MAX        = 8'd100,
    parameter logic [COL_W-1:0] B_MAX        = 8'd100,
    parameter logic [CNT_W-1:0] COUNT_THRESH = 17'd2000,
    parameter int unsigned      HOLD_FRAMES  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_regions,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  x_pos,
    input  logic [PIX_W-1:0]  y_pos,
    input  logic [COL_W-1:0]  R,
    input  logic [COL_W-1:0]  G,
    input  logic [COL_W-1:0]  B,
    output logic              red_flag,
    output logic              green_flag,
    output logic              blue_flag,
    output logic              yellow_flag,
    output logic              flag_valid
);

`ifdef DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif
    // Without debounce a single matching UPD is enough to commit a result
    localparam int unsigned HOLD_REQ = DEB_ON ? HOLD_FRAMES : 1;

    det_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q [NUM_REGIONS];
    logic [CNT_W-1:0]        cnt_d [NUM_REGIONS];
    region_idx_t             cmp_idx_q, cmp_idx_d;
    logic [CNT_W-1:0]        best_cnt_q, best_cnt_d;
    region_idx_t             best_idx_q, best_idx_d;
    logic [NUM_REGIONS-1:0]  flags_q, flags_d;
    logic                    flag_valid_q, flag_valid_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    region_res_t             cand_q, cand_d;
    region_res_t             res;

    logic                    hit_c;
    region_idx_t             region_c;

    glove_pixel_classify #(
        .R_MIN (R_MIN),
        .G_MAX (G_MAX),
        .B_MAX (B_MAX)
    ) u_classify (
        .pix_valid (pix_valid),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .r         (R),
        .g         (G),
        .b         (B),
        .hit_c     (hit_c),
        .region_c  (region_c)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmp_idx_d    = cmp_idx_q;
        best_cnt_d   = best_cnt_q;
        best_idx_d   = best_idx_q;
        flags_d      = flags_q;
        flag_valid_d = 1'b0;
        hold_d       = hold_q;
        cand_d       = cand_q;
        res          = REGION_NONE;

        if (!en_regions) begin
            state_d = IDLE;
            flags_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_d = ACCUM;
                        cnt_d   = '{default: '0};
                    end
                end
                ACCUM: begin
                    // frame_end wins over a simultaneous frame_start
                    if (frame_end) begin
                        state_d    = CMP;
                        cmp_idx_d  = '0;
                        best_cnt_d = '0;
                        best_idx_d = '0;
                    end else if (frame_start) begin
                        cnt_d = '{default: '0};
                    end else if (hit_c && (cnt_q[region_c] != CNT_MAX)) begin
                        cnt_d[region_c] = cnt_q[region_c] + CNT_W'(1);
                    end
                end
                CMP: begin
                    // strict > keeps ties on the lower region index
                    if ((cmp_idx_q == '0) || (cnt_q[cmp_idx_q] > best_cnt_q)) begin
                        best_cnt_d = cnt_q[cmp_idx_q];
                        best_idx_d = cmp_idx_q;
                    end
                    cmp_idx_d = cmp_idx_q + REG_W'(1);
                    if (cmp_idx_q == REG_W'(NUM_REGIONS - 1)) begin
                        state_d = UPD;
                    end
                end
                UPD: begin
                    if (best_cnt_q >= COUNT_THRESH) begin
                        res = '{vld: 1'b1, idx: best_idx_q};
                    end
                    if (res == cand_q) begin
                        hold_d = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);
                    end else begin
                        cand_d = res;
                        hold_d = HOLD_W'(1);
                    end
                    if (hold_d >= HOLD_W'(HOLD_REQ)) begin
                        flags_d = region_onehot(res);
                    end
                    flag_valid_d = 1'b1;
                    state_d      = ACCUM;
                    cnt_d        = '{default: '0};
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '{default: '0};
            cmp_idx_q    <= '0;
            best_cnt_q   <= '0;
            best_idx_q   <= '0;
            flags_q      <= '0;
            flag_valid_q <= 1'b0;
            hold_q       <= '0;
            cand_q       <= REGION_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmp_idx_q    <= cmp_idx_d;
            best_cnt_q   <= best_cnt_d;
            best_idx_q   <= best_idx_d;
            flags_q      <= flags_d;
            flag_valid_q <= flag_valid_d;
            hold_q       <= hold_d;
            cand_q       <= cand_d;
        end
    end

    assign red_flag    = flags_q[0];
    assign green_flag  = flags_q[1];
    assign blue_flag   = flags_q[2];
    assign yellow_flag = flags_q[3];
    assign flag_valid  = flag_valid_q;

endmodule

// File: tb/tb_glove_region_detect.sv
// Directed bench for glove_region_detect: region wins, ties, threshold,
// restarts, reset and enable handling, plus the DEBOUNCE_EN sequence.
module tb_glove_region_detect;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_regions;
    logic       frame_start;
    logic       frame_end;
    logic       pix_valid;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;
    logic       red_flag;
    logic       green_flag;
    logic       blue_flag;
    logic       yellow_flag;
    logic       flag_valid;
    logic [3:0] flags_obs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign flags_obs = {yellow_flag, blue_flag, green_flag, red_flag};

    glove_region_detect dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_regions  (en_regions),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .pix_valid   (pix_valid),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .R           (R),
        .G           (G),
        .B           (B),
        .red_flag    (red_flag),
        .green_flag  (green_flag),
        .blue_flag   (blue_flag),
        .yellow_flag (yellow_flag),
        .flag_valid  (flag_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input int r, input int g, input int b, input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b1;
            x_pos = 10'(x);
            y_pos = 10'(y);
            R = 8'(r);
            G = 8'(g);
            B = 8'(b);
        end
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic glove(input int x, input int n);
        pix(x, 100, 200, 50, 50, n);
    endtask

    task automatic start_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // frame_end sampled at edge E0; expect one flag_valid pulse visible 6 cycles on
    task automatic end_frame(input logic [3:0] exp, input string tag, input bit pix_during);
        int lat;
        int pulses;
        logic [3:0] got;
        lat = 0;
        pulses = 0;
        got = 4'hx;
        @(negedge clk);
        frame_end = 1'b1;
        @(posedge clk);
        #1;
        frame_end = 1'b0;
        if (pix_during) begin
            pix_valid = 1'b1;
            x_pos = 10'd350;
            y_pos = 10'd100;
            R = 8'd200;
            G = 8'd50;
            B = 8'd50;
        end
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (flag_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = n + 1;
                    got = flags_obs;
                end
            end
        end
        pix_valid = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'd6);
        chk({tag, "_pulses"}, 32'(pulses), 32'd1);
        chk({tag, "_flags"}, 32'(got), 32'(exp));
    endtask

    // frame_end that must not produce any update
    task automatic no_update(input logic [3:0] exp, input string tag);
        int pulses;
        pulses = 0;
        @(negedge clk);
        frame_end = 1'b1;
        @(posedge clk);
        #1;
        frame_end = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (flag_valid) pulses++;
        end
        chk({tag, "_fv"}, 32'(pulses), 32'd0);
        chk({tag, "_flags"}, 32'(flags_obs), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        en_regions = 1'b1;
        frame_start = 1'b0;
        frame_end = 1'b0;
        pix_valid = 1'b0;
        x_pos = '0;
        y_pos = '0;
        R = '0;
        G = '0;
        B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", 32'(flags_obs), 32'd0);
        chk("rst_fv", 32'(flag_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef DEBOUNCE_EN
        // green wins; non-glove and off-screen pixels are ignored
        start_frame();
        glove(200, 3000);
        pix(50, 10, 200, 150, 50, 100);
        pix(700, 10, 255, 0, 0, 100);
        pix(100, 480, 255, 0, 0, 100);
        pix(100, 10, 149, 0, 0, 100);
        end_frame(4'b0010, "green", 1'b0);

        // equal counts in regions 0 and 3 go to region 0
        start_frame();
        glove(10, 2500);
        glove(600, 2500);
        end_frame(4'b0001, "tie", 1'b0);

        // 1999 is below threshold; pixels during CMP/UPD must not tip it over
        start_frame();
        glove(350, 1999);
        end_frame(4'b0000, "thr1999", 1'b1);

        start_frame();
        glove(350, 2000);
        end_frame(4'b0100, "thr2000", 1'b0);

        // frame_start inside ACCUM discards the partial count
        start_frame();
        glove(10, 2500);
        start_frame();
        glove(600, 2000);
        end_frame(4'b1000, "restart", 1'b0);

        // region boundary 159/160
        start_frame();
        glove(159, 2000);
        glove(160, 1999);
        end_frame(4'b0001, "x159", 1'b0);

        // synchronous reset mid-frame clears counters, flags and state
        start_frame();
        glove(500, 1000);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_flags", 32'(flags_obs), 32'd0);
        chk("midrst_fv", 32'(flag_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_update(4'b0000, "idle_end");
        start_frame();
        glove(100, 2500);
        glove(500, 1999);
        end_frame(4'b0001, "post_rst", 1'b0);

        // en_regions low mid-frame: flags drop next cycle, no update
        start_frame();
        glove(300, 2500);
        @(negedge clk);
        en_regions = 1'b0;
        @(posedge clk);
        #1;
        chk("en_low_flags", 32'(flags_obs), 32'd0);
        no_update(4'b0000, "en_low");
        @(negedge clk);
        en_regions = 1'b1;
        no_update(4'b0000, "en_back_idle");
        start_frame();
        glove(450, 2000);
        end_frame(4'b0100, "after_en", 1'b0);
`else
        // blue, blue, yellow x3 with HOLD_FRAMES=3: only the 5th UPD commits
        begin
            int xs [5];
            logic [3:0] ex [5];
            xs = '{350, 350, 600, 600, 600};
            ex = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
            for (int f = 0; f < 5; f++) begin
                start_frame();
                glove(xs[f], 2000);
                end_frame(ex[f], $sformatf("deb%0d", f), 1'b0);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/glove_region_detect.md
GLOVE_REGION_DETECT -- requirements
Module: glove_region_detect

Interface
REQ-001 SHALL have parameter R_MIN, default 8'd150, min red component for a glove pixel.
REQ-002 SHALL have parameter G_MAX, default 8'd100, max green component for a glove pixel.
REQ-003 SHALL have parameter B_MAX, default 8'd100, max blue component for a glove pixel.
REQ-004 SHALL have parameter COUNT_THRESH, default 17'd2000, min glove pixels for a region to win.
REQ-005 SHALL have parameter HOLD_FRAMES, default 3, consecutive identical winners required when debounced.
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-007 SHALL have: rst_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have: en_regions  in  1  detection enable.
REQ-009 SHALL have: frame_start  in  1  one-cycle pulse, first pixel of frame follows.
REQ-010 SHALL have: frame_end  in  1  one-cycle pulse after last pixel of frame.
REQ-011 SHALL have: pix_valid  in  1  R/G/B/x_pos/y_pos valid this cycle.
REQ-012 SHALL have: x_pos, y_pos  in  10 each  pixel coordinates.
REQ-013 SHALL have: R, G, B  in  8 each  pixel colour.
REQ-014 SHALL have: red_flag, green_flag, blue_flag, yellow_flag  out  1 each  glove in region 0/1/2/3, registered, at most one high.
REQ-015 SHALL have: flag_valid  out  1  one-cycle pulse when flags are updated.

Function
REQ-016 Regions SHALL be x 0-159 red, 160-319 green, 320-479 blue, 480-639 yellow; pixels with x>=640 or y>=480 SHALL be ignored.
REQ-017 Glove pixel SHALL be pix_valid && R>=R_MIN && G<=G_MAX && B<=B_MAX.
REQ-018 FSM states SHALL be IDLE, ACCUM, CMP, UPD.
REQ-019 IDLE: frame_start with en_regions high -> ACCUM, all four 17-bit counters cleared.
REQ-020 ACCUM: each glove pixel SHALL increment its region counter by 1, saturating at 17'h1FFFF.
REQ-021 ACCUM: frame_end -> CMP; frame_end takes priority over simultaneous frame_start; frame_start alone in ACCUM SHALL clear counters and stay in ACCUM.
REQ-022 CMP SHALL last exactly 4 cycles, examining regions 0..3 one per cycle, keeping the largest count; ties SHALL go to the lower index.
REQ-023 Winner SHALL be valid only if its count >= COUNT_THRESH; otherwise result is "none".
REQ-024 UPD SHALL last 1 cycle, then -> ACCUM with counters cleared (next frame_start expected).
REQ-025 Latency: frame_end at cycle 0 -> flags and flag_valid visible at cycle 6.
REQ-026 Pixels, frame_start and frame_end during CMP/UPD SHALL be ignored.
REQ-027 en_regions low SHALL force all flags to 0 next cycle, suppress flag_valid, and return FSM to IDLE.
REQ-028 frame_end in IDLE SHALL be ignored.

Reset
REQ-029 rst_n low at a clock edge SHALL set state IDLE, counters 0, all flags 0, flag_valid 0, hold counter 0, mid-frame included.

Configuration
REQ-030 With DEBOUNCE_EN defined, flags SHALL change only after the same result (including "none") in HOLD_FRAMES consecutive UPDs; flag_valid SHALL pulse every UPD.
REQ-031 Without DEBOUNCE_EN, flags SHALL take each UPD result directly.

Structure
REQ-032 Region boundary constants (160/320/480/640/480), region index encoding (2-bit + none) and FSM state typedef SHALL live in shared package vision_pkg, also used by drawShape's successors.
REQ-033 Sub-module glove_pixel_classify SHALL implement REQ-016/017 combinationally, outputting hit and 2-bit region.

Verification
REQ-034 Frame with 3000 glove pixels at x=200, others non-glove -> green_flag=1 only, flag_valid at frame_end+6 (no debounce).
REQ-035 Regions 0 and 3 each 2500 glove pixels -> red_flag=1 (tie to lower index).
REQ-036 Max region 1999 pixels -> all flags 0; 2000 -> flag set.
REQ-037 DEBOUNCE_EN, HOLD_FRAMES=3: blue, blue, yellow, yellow, yellow frames -> blue_flag never set, yellow_flag set after 5th UPD.
REQ-038 rst_n low mid-ACCUM with 1000 counted -> next frame of 2500 at x=100 gives red_flag; en_regions low mid-frame -> flags 0, no flag_valid.
